rf_multiport: RTL and testbench
===============================

# rf_multiport

Parametrised successor to the CPU's 32×32 register file. Width, depth and read-port count are configurable, and the block adds:

- byte-masked writes;
- optional write-to-read bypass;
- a freeze input that blocks architectural writes (replaces the old sw_i[1] gating);
- a registered debug read port;
- a cycle-by-cycle initialisation sequencer, replacing the single-cycle bulk reset loop.

It sits between the decode/writeback stages of the single-cycle and pipelined datapaths and the board debug display.

## Interface

Parameters:
- DW, 32: data width in bits; must be a multiple of 8.
- AW, 5: address width; DEPTH = 2**AW entries.
- NR, 2: number of architectural read ports, 1..4.
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching read ports; 0 = read returns stored value.
- INIT_ZERO, 0: 0 = entry i initialises to i (zero-extended/truncated to DW); 1 = all entries initialise to 0.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- freeze, input, 1: while 1, blocks writes and pauses the init sequencer.
- wr_en, input, 1: write request.
- wr_addr, input, AW: write address.
- wr_be, input, DW/8: byte enables; bit k covers bits [8k+7:8k].
- wr_data, input, DW: write data.
- wr_ok, output, 1: combinational; write accepted this cycle.
- rd_addr, input, NR*AW: port p address is in slice [p*AW +: AW].
- rd_data, output, NR*DW: port p data is in slice [p*DW +: DW]; combinational.
- dbg_addr, input, AW: debug read address.
- dbg_data, output, DW: registered debug read data.
- busy, output, 1: init sequence in progress.

## Operation

- State machine with two states, INIT and READY. Internal pointer ptr is AW bits wide.
- rst asserted (asynchronous):
  - state = INIT, ptr = 1.
  - busy = 1, dbg_data = 0.
  - Storage contents are not reset directly; they are rewritten by the sequencer.
- INIT state:
  - Each clock with freeze=0: store the init value into entry ptr, then ptr increments.
  - When ptr == DEPTH-1 is written, the next state is READY and busy goes 0.
  - With freeze=1: ptr holds and nothing is written.
- Entry 0 is hardwired to zero. It is never written, and reads of address 0 return 0 on every port including debug.
- Writes:
  - wr_ok = wr_en & (state==READY) & ~freeze & (wr_addr != 0).
  - When wr_ok is 1, each byte k with wr_be[k]=1 is replaced by wr_data's byte k at the clock edge. Other bytes are kept.
  - wr_be = 0 with wr_ok = 1 is legal and is a no-op.
  - A write refused while busy or frozen is dropped silently; it is not queued.
- Architectural reads (each port p independently):
  - busy=1: rd_data = 0.
  - addr == 0: rd_data = 0.
  - BYPASS=1, wr_ok=1 and addr == wr_addr: rd_data = the merged word, i.e. the stored word with enabled bytes replaced by wr_data.
  - Otherwise: the stored entry.
  - Multiple ports may read the same address.
- Debug read:
  - dbg_data <= (dbg_addr==0 || busy) ? 0 : stored entry, every clock regardless of freeze.
  - No bypass; a same-cycle write becomes visible one cycle later than the write edge.
- rst asserted mid-INIT or mid-write: the sequencer restarts from ptr=1 and any in-flight write is lost.

## Timing

- Write latency: data is stored at the rising edge where wr_ok=1. A read in the next cycle returns it with bypass off; with BYPASS=1 it is visible in the same cycle.
- Read latency: 0 cycles (combinational) on the architectural ports; 1 cycle on the debug port.
- Init duration: exactly DEPTH-1 un-frozen clock edges after rst deasserts. For AW=5 busy falls after 31 edges. Each frozen cycle extends this by one.
- Reset values: busy=1, dbg_data=0, rd_data=0 (forced by busy). wr_ok=0 (forced by state INIT).
- Simultaneous events:
  - A write and a debug read of the same address on the same edge: dbg_data gets the old value.
  - freeze rising in the same cycle as wr_en: the write is dropped.

## Test plan

- Reset/init:
  - Pulse rst, then hold freeze=0 and rd_addr port0=5.
  - Required: busy=1 for exactly 31 cycles with rd_data=0.
  - After busy falls, port0 reads 0x00000005, and reading entry 31 gives 0x0000001F.
- Freeze during init:
  - Assert freeze for 4 cycles at cycle 10 of init.
  - Required: busy falls after 35 cycles and every entry still holds its index.
- Byte-masked write with bypass:
  - In READY, write addr 3 with wr_be=4'b0101 and wr_data=0xAABBCCDD, with port1 addr=3 in the same cycle.
  - Required: port1 = 0x00BB00DD in that cycle (old value 3 has upper bytes 0); next cycle the stored value reads the same.
  - Required with BYPASS=0: port1 = 0x00000003 in the write cycle.
- Register zero and dropped writes:
  - Write 0xFFFFFFFF to addr 0: required wr_ok=0 and reads of addr 0 return 0.
  - Write during busy: required wr_ok=0 and the entry is unchanged after init.
  - Write with freeze=1: required wr_ok=0 and the entry is unchanged.
- Debug port latency: write 0x12345678 to addr 7 while dbg_addr=7. Required: dbg_data shows the old value (7) the cycle after the write edge and 0x12345678 one cycle later.
- Mid-operation reset: assert rst asynchronously between edges during a write burst. Required: busy=1 and dbg_data=0 immediately, and entry values are restored to indices after a full init.

Source files
------------

// File: rtl/rf_multiport_if.sv
// Bundle of register-file access signals: write port, architectural read ports, debug read, status.
// The master side (datapath/bench) drives requests and the slave side (rf_multiport) returns data.
interface rf_multiport_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
);
  logic             freeze;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW/8-1:0]  wr_be;
  logic [DW-1:0]    wr_data;
  logic             wr_ok;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_data;
  logic             busy;

  modport master (
    output freeze, wr_en, wr_addr, wr_be, wr_data, rd_addr, dbg_addr,
    input  wr_ok, rd_data, dbg_data, busy
  );

  modport slave (
    input  freeze, wr_en, wr_addr, wr_be, wr_data, rd_addr, dbg_addr,
    output wr_ok, rd_data, dbg_data, busy
  );
endinterface

// File: rtl/rf_multiport.sv
// Multi-port register file with byte-masked writes, optional bypass and a sequential init walk.
// Reads are combinational (debug port 1 cycle); writes refused while busy/frozen are dropped, not held.
module rf_multiport #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int NR        = 2,
  parameter int BYPASS    = 1,
  parameter int INIT_ZERO = 0
) (
  input  logic          clk,
  input  logic          rst,
  rf_multiport_if.slave bus
);
  localparam int DEPTH = 2 ** AW;
  localparam int BW    = DW / 8;

  typedef enum logic {INIT, READY} state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic             busy_q;
  logic [DW-1:0]    dbg_q;
  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    init_val;
  logic [DW-1:0]    merged;
  logic [NR*DW-1:0] rd;
  logic             wr_ok;

  assign init_val = (INIT_ZERO != 0) ? '0 : DW'(ptr);
  assign wr_ok    = bus.wr_en && (state == READY) && !bus.freeze && (bus.wr_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INIT;
      ptr    <= AW'(1);
      busy_q <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (!bus.freeze) begin
            ptr <= ptr + 1'b1;
            if (&ptr) begin
              state  <= READY;
              busy_q <= 1'b0;
            end
          end
        end
        READY:   state <= READY;
        default: state <= INIT;
      endcase
    end
  end

  // Entry 0 is never written: the walk starts at 1 and leaves INIT right after the last entry.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      if (!bus.freeze) mem[ptr] <= init_val;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= merged;
    end
  end

  always_comb begin
    merged = mem[bus.wr_addr];
    for (int k = 0; k < BW; k++) begin
      if (bus.wr_be[k]) merged[8*k +: 8] = bus.wr_data[8*k +: 8];
    end
  end

  always_comb begin
    rd = '0;
    for (int p = 0; p < NR; p++) begin
      if (!busy_q && (bus.rd_addr[p*AW +: AW] != '0)) begin
        if ((BYPASS != 0) && wr_ok && (bus.rd_addr[p*AW +: AW] == bus.wr_addr))
          rd[p*DW +: DW] = merged;
        else
          rd[p*DW +: DW] = mem[bus.rd_addr[p*AW +: AW]];
      end
    end
  end

  // Debug port deliberately sees the pre-edge contents of a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= (busy_q || (bus.dbg_addr == '0)) ? '0 : mem[bus.dbg_addr];
    end
  end

  assign bus.wr_ok    = wr_ok;
  assign bus.rd_data  = rd;
  assign bus.dbg_data = dbg_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench: two DUTs (bypass on/off) share stimulus; expectations come from an array model.
module tb_rf_multiport;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic             clk = 1'b0;
  logic             rst;
  logic             freeze, wr_en;
  logic [AW-1:0]    wr_addr, dbg_addr;
  logic [BW-1:0]    wr_be;
  logic [DW-1:0]    wr_data;
  logic [NR*AW-1:0] rd_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_multiport_if #(.DW(DW), .AW(AW), .NR(NR)) ifa ();
  rf_multiport_if #(.DW(DW), .AW(AW), .NR(NR)) ifb ();

  assign ifa.freeze = freeze;   assign ifb.freeze = freeze;
  assign ifa.wr_en = wr_en;     assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
  assign ifa.wr_be = wr_be;     assign ifb.wr_be = wr_be;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;
  assign ifa.dbg_addr = dbg_addr; assign ifb.dbg_addr = dbg_addr;

  rf_multiport #(.DW(DW), .AW(AW), .NR(NR), .BYPASS(1), .INIT_ZERO(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  rf_multiport #(.DW(DW), .AW(AW), .NR(NR), .BYPASS(0), .INIT_ZERO(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  // Reference model: architectural contents plus count of init edges still owed.
  logic [DW-1:0] mmem [DEPTH];
  int            remaining;
  logic [DW-1:0] dbg_exp;

  typedef struct {
    logic             busy;
    logic             wok;
    logic [NR*DW-1:0] rdb;
    logic [NR*DW-1:0] rdn;
    logic [DW-1:0]    dbg;
  } exp_t;

  exp_t q[$];

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [BW-1:0] be, logic [DW-1:0] d);
    logic [DW-1:0] r = old;
    for (int k = 0; k < BW; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mmem[i] = DW'(i);
    remaining = DEPTH - 1;
    dbg_exp   = '0;
  endtask

  task automatic push_exp();
    exp_t e;
    logic [AW-1:0] a;
    logic b;
    b      = (remaining > 0);
    e.busy = b;
    e.wok  = wr_en && !b && !freeze && (wr_addr != 0) && !rst;
    e.rdb  = '0;
    e.rdn  = '0;
    for (int p = 0; p < NR; p++) begin
      a = rd_addr[p*AW +: AW];
      if (!b && a != 0) begin
        e.rdn[p*DW +: DW] = mmem[a];
        e.rdb[p*DW +: DW] = (e.wok && a == wr_addr) ? merge(mmem[a], wr_be, wr_data) : mmem[a];
      end
    end
    e.dbg = dbg_exp;
    q.push_back(e);
  endtask

  task automatic step();
    logic b, w;
    push_exp();
    @(posedge clk);
    if (!rst) begin
      b = (remaining > 0);
      w = wr_en && !b && !freeze && (wr_addr != 0);
      dbg_exp = (b || dbg_addr == 0) ? '0 : mmem[dbg_addr];
      if (w) mmem[wr_addr] = merge(mmem[wr_addr], wr_be, wr_data);
      if (b && !freeze) remaining--;
    end
    #1;
  endtask

  // Called just after an edge; asserts rst between edges with current inputs still applied.
  task automatic reset_async();
    #2;
    rst = 1'b1;
    model_reset();
    push_exp();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle();
    wr_en = 1'b0; freeze = 1'b0; wr_be = '0; wr_data = '0; wr_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    rd_addr = {p1, p0};
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      set_rd(AW'(i), AW'(DEPTH - 1 - i));
      dbg_addr = AW'(i);
      step();
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("busy_a",  64'(ifa.busy),     64'(me.busy));
        chk("busy_b",  64'(ifb.busy),     64'(me.busy));
        chk("wr_ok_a", 64'(ifa.wr_ok),    64'(me.wok));
        chk("wr_ok_b", 64'(ifb.wr_ok),    64'(me.wok));
        chk("rd_byp",  64'(ifa.rd_data),  64'(me.rdb));
        chk("rd_nob",  64'(ifb.rd_data),  64'(me.rdn));
        chk("dbg_a",   64'(ifa.dbg_data), 64'(me.dbg));
        chk("dbg_b",   64'(ifb.dbg_data), 64'(me.dbg));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = '0;
    dbg_addr = '0;
    model_reset();
    @(posedge clk);
    #1;
    set_rd(5'd5, 5'd31);
    dbg_addr = 5'd5;
    push_exp();                       // reset state while rst held
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Plain init: 31 busy cycles, then indices visible.
    repeat (34) step();

    // Freeze for 4 cycles at cycle 10 of a fresh init.
    reset_async();
    repeat (10) step();
    freeze = 1'b1;
    repeat (4) step();
    freeze = 1'b0;
    repeat (24) step();
    sweep();

    // Byte-masked write with bypass on port 1, then stored value next cycle.
    set_rd(5'd0, 5'd3);
    write(5'd3, 4'b0101, 32'hAABBCCDD);
    step();
    idle();
    step();

    // Writes to register zero.
    set_rd(5'd0, 5'd0);
    dbg_addr = 5'd0;
    write(5'd0, 4'hF, 32'hFFFFFFFF);
    step();
    idle();
    step();

    // Frozen write dropped (freeze asserted with wr_en in the same cycle).
    set_rd(5'd12, 5'd12);
    write(5'd12, 4'hF, 32'hDEADBEEF);
    freeze = 1'b1;
    step();
    idle();
    step();

    // Debug latency: old value one cycle after the edge, new value one later.
    dbg_addr = 5'd7;
    set_rd(5'd7, 5'd1);
    write(5'd7, 4'hF, 32'h12345678);
    step();
    idle();
    repeat (3) step();

    // Writes during busy are dropped.
    reset_async();
    set_rd(5'd9, 5'd9);
    dbg_addr = 5'd9;
    for (int i = 0; i < 40; i++) begin
      write(5'd9, 4'hF, 32'hFFFF0000 | 32'(i));
      step();
    end
    idle();
    step();

    // Randomised traffic with frequent bypass hits and occasional freeze.
    for (int i = 0; i < 400; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom);
      wr_be    = BW'($urandom);
      wr_data  = $urandom;
      freeze   = ($urandom_range(0, 9) == 0);
      rd_addr  = (NR*AW)'($urandom);
      dbg_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr[0 +: AW] = wr_addr;
      if ($urandom_range(0, 2) == 0) rd_addr[AW +: AW] = wr_addr;
      step();
    end

    // Reset in the middle of a write burst, then full init restores indices.
    for (int i = 0; i < 6; i++) begin
      write(AW'(i + 20), 4'hF, 32'hCAFE0000 | 32'(i));
      set_rd(AW'(i + 20), 5'd20);
      step();
    end
    write(5'd26, 4'hF, 32'h0BADF00D);
    reset_async();
    idle();
    repeat (DEPTH - 1) step();
    sweep();

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
